// File: rtl/cnn_pkg.sv
// Types and defaults shared by the CNN streaming blocks.
// Pixels are signed and are passed between stages bit-exactly.
package cnn_pkg;
    localparam int DATA_W    = 8;
    localparam int IMG_W_DEF = 28;
    localparam int IMG_H_DEF = 28;

    typedef logic signed [DATA_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ROW_TOP = 2'd1,
        ST_ROW_BOT = 2'd2
    } pool_win_state_t;

    // Index width for a counter or address over n entries; a 1-entry range still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/pool_window_gen_if.sv
// Pixel stream in, 2x2 window strobe out, plus frame control.
// The master side is the producer/consumer; the slave side is the window generator.
interface pool_window_gen_if;
    import cnn_pkg::*;

    logic   start;
    logic   in_valid;
    pixel_t in_data;
    logic   win_valid;
    pixel_t win_tl;
    pixel_t win_tr;
    pixel_t win_bl;
    pixel_t win_br;
    logic   busy;
    logic   frame_done;

    modport master (
        output start, in_valid, in_data,
        input  win_valid, win_tl, win_tr, win_bl, win_br, busy, frame_done
    );

    modport slave (
        input  start, in_valid, in_data,
        output win_valid, win_tl, win_tr, win_bl, win_br, busy, frame_done
    );
endinterface

// File: rtl/pair_line_buffer.sv
// Half-row buffer of horizontal pixel pairs from the top row of each 2x2 block.
// Synchronous write, asynchronous read, so it maps onto distributed RAM.
module pair_line_buffer #(
    parameter int DEPTH  = 14,
    parameter int ADDR_W = 4,
    parameter int WIDTH  = 16
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/pool_window_gen.sv
// Streaming stride-2 2x2 window generator feeding the max-pooling stage.
// state      | meaning
// ST_IDLE    | waiting for start; in_valid ignored
// ST_ROW_TOP | even row: pair pixels into the line buffer
// ST_ROW_BOT | odd row: combine with buffered pair, emit windows
module pool_window_gen
    import cnn_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
) (
    input logic              clk,
    input logic              reset,
    pool_window_gen_if.slave bus
);
    localparam int COL_W  = idx_w(IMG_W);
    localparam int ROW_W  = idx_w(IMG_H);
    localparam int ADDR_W = idx_w(IMG_W / 2);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    pool_win_state_t     state, next_state;
    logic [COL_W-1:0]    col;
    logic [ROW_W-1:0]    row;
    pixel_t              left;
    logic                accept, last_col, last_row;
    logic                wr_en, fire;
    logic [ADDR_W-1:0]   pair_addr;
    logic [2*DATA_W-1:0] rd_pair;

    assign accept    = bus.in_valid && (state != ST_IDLE);
    assign last_col  = (col == COL_LAST);
    assign last_row  = (row == ROW_LAST);
    assign pair_addr = ADDR_W'(col >> 1);
    assign bus.busy  = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        wr_en      = 1'b0;
        fire       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) next_state = ST_ROW_TOP;
            end
            ST_ROW_TOP: begin
                wr_en = accept && col[0];
                if (accept && last_col) next_state = ST_ROW_BOT;
            end
            ST_ROW_BOT: begin
                fire = accept && col[0];
                if (accept && last_col) next_state = last_row ? ST_IDLE : ST_ROW_TOP;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Counters wrap at the end of the frame too, so they are already zero at the next start.
    always_ff @(posedge clk) begin
        if (reset || (state == ST_IDLE && bus.start)) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)                   left <= '0;
        else if (accept && !col[0])  left <= bus.in_data;
    end

    pair_line_buffer #(
        .DEPTH  (IMG_W / 2),
        .ADDR_W (ADDR_W),
        .WIDTH  (2 * DATA_W)
    ) u_pair_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (pair_addr),
        .wr_data ({left, bus.in_data}),
        .rd_addr (pair_addr),
        .rd_data (rd_pair)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.win_valid  <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.win_tl     <= '0;
            bus.win_tr     <= '0;
            bus.win_bl     <= '0;
            bus.win_br     <= '0;
        end else begin
            bus.win_valid  <= fire;
            bus.frame_done <= fire && last_col && last_row;
            if (fire) begin
                bus.win_tl <= pixel_t'(rd_pair[2*DATA_W-1:DATA_W]);
                bus.win_tr <= pixel_t'(rd_pair[DATA_W-1:0]);
                bus.win_bl <= left;
                bus.win_br <= bus.in_data;
            end
        end
    end
endmodule

// File: tb/tb_pool_window_gen.sv
// Directed bench for pool_window_gen: 4x4, 2x2 and 28x28 instances with a
// hand-computed or image-derived expected window list.
module tb_pool_window_gen;
    import cnn_pkg::*;

    typedef struct packed {
        pixel_t tl;
        pixel_t tr;
        pixel_t bl;
        pixel_t br;
        logic   fd;
    } win_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    win_t q4[$];
    win_t q2[$];
    win_t q28[$];
    win_t exp4[4];
    pixel_t img [28][28];

    always #5 clk = ~clk;

    pool_window_gen_if if4 ();
    pool_window_gen_if if2 ();
    pool_window_gen_if if28 ();

    pool_window_gen #(.IMG_W(4),  .IMG_H(4))  u4  (.clk(clk), .reset(reset), .bus(if4));
    pool_window_gen #(.IMG_W(2),  .IMG_H(2))  u2  (.clk(clk), .reset(reset), .bus(if2));
    pool_window_gen #(.IMG_W(28), .IMG_H(28)) u28 (.clk(clk), .reset(reset), .bus(if28));

    task automatic fail(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic win_t mk(input int tl, input int tr, input int bl, input int br, input bit fd);
        win_t w;
        w.tl = pixel_t'(tl);
        w.tr = pixel_t'(tr);
        w.bl = pixel_t'(bl);
        w.br = pixel_t'(br);
        w.fd = fd;
        return w;
    endfunction

    always @(negedge clk) begin
        if (if4.win_valid)  q4.push_back({if4.win_tl, if4.win_tr, if4.win_bl, if4.win_br, if4.frame_done});
        if (if2.win_valid)  q2.push_back({if2.win_tl, if2.win_tr, if2.win_bl, if2.win_br, if2.frame_done});
        if (if28.win_valid) q28.push_back({if28.win_tl, if28.win_tr, if28.win_bl, if28.win_br, if28.frame_done});
    end

    task automatic beat4(input int d, input int gap);
        repeat (gap) begin
            @(negedge clk);
            if4.in_valid = 1'b0;
        end
        @(negedge clk);
        if4.in_valid = 1'b1;
        if4.in_data  = pixel_t'(d);
    endtask

    task automatic idle4(input int n);
        repeat (n) begin
            @(negedge clk);
            if4.in_valid = 1'b0;
        end
    endtask

    task automatic start4();
        @(negedge clk);
        if4.start = 1'b1;
        @(negedge clk);
        if4.start = 1'b0;
    endtask

    task automatic check_q4(input string tag);
        total++; if (q4.size() !== 4) fail(tag, q4.size(), 4);
        for (int i = 0; i < 4 && i < q4.size(); i++) begin
            total++;
            if (q4[i] !== exp4[i]) fail(tag, q4[i], exp4[i]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int fd_cnt;
        logic exp_strobe;
        if4.start = 0;  if4.in_valid = 0;  if4.in_data = '0;
        if2.start = 0;  if2.in_valid = 0;  if2.in_data = '0;
        if28.start = 0; if28.in_valid = 0; if28.in_data = '0;
        exp4[0] = mk(1, 2, 5, 6, 1'b0);
        exp4[1] = mk(3, 4, 7, 8, 1'b0);
        exp4[2] = mk(9, 10, 13, 14, 1'b0);
        exp4[3] = mk(11, 12, 15, 16, 1'b1);

        // reset values
        repeat (3) @(negedge clk);
        reset = 1'b0;
        total++; if (if4.win_valid !== 1'b0) fail("rst_win_valid", if4.win_valid, 1'b0);
        total++; if (if4.busy !== 1'b0) fail("rst_busy", if4.busy, 1'b0);
        total++; if (if4.frame_done !== 1'b0) fail("rst_frame_done", if4.frame_done, 1'b0);
        total++; if (if4.win_tl !== 8'h00) fail("rst_win_tl", if4.win_tl, 8'h00);
        total++; if (if4.win_br !== 8'h00) fail("rst_win_br", if4.win_br, 8'h00);

        // contiguous 4x4 frame with per-cycle strobe timing
        q4.delete();
        @(negedge clk);
        if4.start = 1'b1;
        total++; if (if4.busy !== 1'b0) fail("s1_busy_pre", if4.busy, 1'b0);
        @(negedge clk);
        if4.start = 1'b0;
        total++; if (if4.busy !== 1'b1) fail("s1_busy_rise", if4.busy, 1'b1);
        if4.in_valid = 1'b1;
        if4.in_data  = pixel_t'(1);
        for (int k = 2; k <= 16; k++) begin
            @(negedge clk);
            exp_strobe = (k - 1 == 6 || k - 1 == 8 || k - 1 == 14);
            total++; if (if4.win_valid !== exp_strobe) fail("s1_strobe", if4.win_valid, exp_strobe);
            total++; if (if4.busy !== 1'b1) fail("s1_busy", if4.busy, 1'b1);
            if4.in_data = pixel_t'(k);
        end
        @(negedge clk);
        if4.in_valid = 1'b0;
        total++; if (if4.win_valid !== 1'b1) fail("s1_last_strobe", if4.win_valid, 1'b1);
        total++; if (if4.frame_done !== 1'b1) fail("s1_frame_done", if4.frame_done, 1'b1);
        total++; if (if4.busy !== 1'b0) fail("s1_busy_fall", if4.busy, 1'b0);
        @(negedge clk);
        total++; if (if4.win_valid !== 1'b0) fail("s1_strobe_drop", if4.win_valid, 1'b0);
        total++; if (if4.win_br !== 8'd16) fail("s1_hold_br", if4.win_br, 8'd16);
        check_q4("s1_win");

        // same frame with random gaps
        q4.delete();
        start4();
        for (int k = 1; k <= 16; k++) beat4(k, $urandom_range(0, 3));
        idle4(4);
        check_q4("s2_win");

        // stray in_valid in IDLE, start mid-frame and with the final beat
        q4.delete();
        @(negedge clk);
        if4.in_valid = 1'b1;
        if4.in_data  = 8'sh55;
        idle4(1);
        idle4(2);
        total++; if (if4.busy !== 1'b0) fail("s3_idle_busy", if4.busy, 1'b0);
        total++; if (q4.size() !== 0) fail("s3_idle_nowin", q4.size(), 0);
        start4();
        for (int k = 1; k <= 16; k++) begin
            beat4(k, 0);
            if (k == 5 || k == 16) if4.start = 1'b1;
            if (k == 7) if4.start = 1'b0;
        end
        @(negedge clk);
        if4.start = 1'b0;
        if4.in_valid = 1'b0;
        total++; if (if4.busy !== 1'b0) fail("s3_busy_end", if4.busy, 1'b0);
        @(negedge clk);
        total++; if (if4.busy !== 1'b0) fail("s3_start_ignored", if4.busy, 1'b0);
        check_q4("s3_win");

        // reset mid-frame, then a clean frame
        q4.delete();
        start4();
        for (int k = 1; k <= 10; k++) beat4(k, 0);
        @(negedge clk);
        if4.in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++; if (if4.busy !== 1'b0) fail("s4_rst_busy", if4.busy, 1'b0);
        total++; if (if4.win_valid !== 1'b0) fail("s4_rst_win_valid", if4.win_valid, 1'b0);
        total++; if (if4.win_tl !== 8'h00) fail("s4_rst_win_tl", if4.win_tl, 8'h00);
        total++; if (if4.frame_done !== 1'b0) fail("s4_rst_frame_done", if4.frame_done, 1'b0);
        fd_cnt = 0;
        foreach (q4[i]) fd_cnt += int'(q4[i].fd);
        total++; if (q4.size() !== 2) fail("s4_partial_windows", q4.size(), 2);
        total++; if (fd_cnt !== 0) fail("s4_no_frame_done", fd_cnt, 0);
        q4.delete();
        start4();
        for (int k = 1; k <= 16; k++) beat4(k, 0);
        idle4(3);
        check_q4("s4_win");

        // signed extremes on the 2x2 instance
        @(negedge clk);
        if2.start = 1'b1;
        @(negedge clk);
        if2.start = 1'b0;
        if2.in_valid = 1'b1;
        if2.in_data = 8'sh80;
        @(negedge clk);
        if2.in_data = 8'sh7F;
        @(negedge clk);
        if2.in_data = 8'shFF;
        @(negedge clk);
        if2.in_data = 8'sh00;
        @(negedge clk);
        if2.in_valid = 1'b0;
        @(negedge clk);
        total++; if (q2.size() !== 1) fail("s5_count", q2.size(), 1);
        if (q2.size() > 0) begin
            total++; if (q2[0].tl !== 8'h80) fail("s5_tl", q2[0].tl, 8'h80);
            total++; if (q2[0].tr !== 8'h7F) fail("s5_tr", q2[0].tr, 8'h7F);
            total++; if (q2[0].bl !== 8'hFF) fail("s5_bl", q2[0].bl, 8'hFF);
            total++; if (q2[0].br !== 8'h00) fail("s5_br", q2[0].br, 8'h00);
            total++; if (q2[0].fd !== 1'b1) fail("s5_fd", q2[0].fd, 1'b1);
        end

        // full 28x28 frame against blocks cut from the image
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++) img[r][c] = pixel_t'($urandom_range(0, 255));
        @(negedge clk);
        if28.start = 1'b1;
        @(negedge clk);
        if28.start = 1'b0;
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++) begin
                if28.in_valid = 1'b1;
                if28.in_data  = img[r][c];
                @(negedge clk);
            end
        if28.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (q28.size() !== 196) fail("s6_count", q28.size(), 196);
        fd_cnt = 0;
        foreach (q28[i]) fd_cnt += int'(q28[i].fd);
        total++; if (fd_cnt !== 1) fail("s6_frame_done_count", fd_cnt, 1);
        for (int br = 0; br < 14; br++)
            for (int bc = 0; bc < 14; bc++) begin
                int n;
                win_t w;
                n = br * 14 + bc;
                w.tl = img[2*br][2*bc];
                w.tr = img[2*br][2*bc+1];
                w.bl = img[2*br+1][2*bc];
                w.br = img[2*br+1][2*bc+1];
                w.fd = (n == 195);
                if (n < q28.size()) begin
                    total++;
                    if (q28[n] !== w) fail("s6_win", q28[n], w);
                end
            end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
